// File: rtl/tk_pkg.sv
// rtl/tk_pkg.sv - shared encodings, limits and segment table for the timekeeper
package tk_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } edit_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    // Active-low "all segments off"
    localparam logic [6:0] BLANK = 7'h7F;

    // Active-high {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/timekeeper_display_bin2seg2.sv
// rtl/timekeeper_display_bin2seg2.sv - binary 0..59 to two active-high 7-segment codes
module bin2seg2
    import tk_pkg::*;
(
    input  logic [5:0] bin_i,
    output logic [6:0] tens_o,
    output logic [6:0] units_o
);

    logic [3:0] tens_w;
    logic [3:0] units_w;

    // Inputs never exceed 59, so both quotient and remainder fit in four bits
    assign tens_w  = 4'(bin_i / 6'd10);
    assign units_w = 4'(bin_i % 6'd10);

    assign tens_o  = SEG_TABLE[tens_w];
    assign units_o = SEG_TABLE[units_w];

endmodule

// File: rtl/timekeeper_display.sv
// rtl/timekeeper_display.sv - hh:mm:ss timekeeper with multiplexed 4-digit 7-segment driver
module timekeeper_display
    import tk_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_BITS = 18,
    parameter int DIV_W     = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       view_sec_i,
    input  logic       mode_12h_i,
    output logic [6:0] segments_o,
    output logic       dp_o,
    output logic [3:0] anodes_o,
    output logic       pm_o,
    output logic [1:0] edit_o,
    output logic       tick_1hz_o
);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick_q;
    logic                 phase;
    logic [5:0]           sec_q, sec_d, min_q, min_d;
    logic [4:0]           hr_q, hr_d;
    edit_t                state_q, state_d;
    logic [SCAN_BITS-1:0] scan_q;
    logic [1:0]           sel;
    logic [4:0]           hr_disp;
    logic [6:0]           hr_t, hr_u, min_t, min_u, sec_t, sec_u;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           an_q, an_d;
    logic                 blank_hi, blank_lo;

    assign div_d = (div_q == DIV_W'(CLK_HZ - 1)) ? '0 : div_q + 1'b1;
    assign phase = (div_q < DIV_W'(CLK_HZ / 2));
    assign sel   = scan_q[SCAN_BITS-1 -: 2];

    // Prescaler, scan counter and the registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            scan_q <= '0;
            seg_q  <= BLANK;
            dp_q   <= 1'b1;
            an_q   <= 4'hF;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_q == DIV_W'(CLK_HZ - 1));
            scan_q <= scan_q + 1'b1;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    // Edit state and time-of-day registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
        end
    end

    // Mode stepping, time-setting and running count; a mode press swallows a coincident inc
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        case (state_q)
            RUN: begin
                if (btn_mode_i) begin
                    state_d = SET_HR;
                    sec_d   = '0;
                end else if (tick_q) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d = '0;
                            hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_HR: begin
                sec_d = '0;
                if (btn_mode_i) begin
                    state_d = SET_MIN;
                end else if (btn_inc_i) begin
                    hr_d = (hr_q == HR_MAX) ? '0 : hr_q + 5'd1;
                end
            end
            SET_MIN: begin
                sec_d = '0;
                if (btn_mode_i) begin
                    state_d = RUN;
                end else if (btn_inc_i) begin
                    min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // 12-hour folding: 0 shows as 12, afternoon hours drop by 12
    always_comb begin
        hr_disp = hr_q;
        if (mode_12h_i) begin
            if (hr_q == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr_q > 5'd12) begin
                hr_disp = hr_q - 5'd12;
            end
        end
    end

    bin2seg2 u_hr  (.bin_i({1'b0, hr_disp}), .tens_o(hr_t),  .units_o(hr_u));
    bin2seg2 u_min (.bin_i(min_q),           .tens_o(min_t), .units_o(min_u));
    bin2seg2 u_sec (.bin_i(sec_q),           .tens_o(sec_t), .units_o(sec_u));

    // Blink the pair showing the field under edit during the second half of each second
    assign blank_hi = !phase && (((state_q == SET_HR) && !view_sec_i) ||
                                 ((state_q == SET_MIN) && view_sec_i));
    assign blank_lo = !phase && (state_q == SET_MIN) && !view_sec_i;

    // Next digit pattern, colon and anode for the selected position
    always_comb begin
        seg_d = BLANK;
        case (sel)
            2'd3:    seg_d = blank_hi ? BLANK : ~(view_sec_i ? min_t : hr_t);
            2'd2:    seg_d = blank_hi ? BLANK : ~(view_sec_i ? min_u : hr_u);
            2'd1:    seg_d = blank_lo ? BLANK : ~(view_sec_i ? sec_t : min_t);
            default: seg_d = blank_lo ? BLANK : ~(view_sec_i ? sec_u : min_u);
        endcase
        dp_d = 1'b1;
        if (sel == 2'd2) begin
            dp_d = (state_q == RUN) ? ~phase : 1'b0;
        end
        an_d = ~(4'b0001 << sel);
    end

    assign segments_o = seg_q;
    assign dp_o       = dp_q;
    assign anodes_o   = an_q;
    assign pm_o       = mode_12h_i && (hr_q >= 5'd12);
    assign edit_o     = state_q;
    assign tick_1hz_o = tick_q;

endmodule

// File: tb/tb_timekeeper_display.sv
// tb/tb_timekeeper_display.sv - directed self-checking bench for timekeeper_display
module tb_timekeeper_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       view_sec = 1'b0;
    logic       mode_12h = 1'b0;
    logic [6:0] segments;
    logic       dp;
    logic [3:0] anodes;
    logic       pm;
    logic [1:0] edit;
    logic       tick_1hz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ticks   = 0;

    localparam int B = 10;

    logic [6:0]  seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [27:0] rd_segs;
    logic [3:0]  rd_dps;

    timekeeper_display #(.CLK_HZ(10), .SCAN_BITS(4), .DIV_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode_i (btn_mode),
        .btn_inc_i  (btn_inc),
        .view_sec_i (view_sec),
        .mode_12h_i (mode_12h),
        .segments_o (segments),
        .dp_o       (dp),
        .anodes_o   (anodes),
        .pm_o       (pm),
        .edit_o     (edit),
        .tick_1hz_o (tick_1hz)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the prescaler count the bench expects
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (tick_1hz) ticks <= ticks + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] sg(input int v);
        if (v < 0)  return 7'h00;
        if (v == B) return 7'h7F;
        return ~seg_ref[v];
    endfunction

    // want: 1 = only sample in the first half-second, 0 = only second half, 2 = any
    task automatic read_disp(input int want);
        logic [3:0] got = 4'h0;
        logic [3:0] pat;
        bit         ph;
        int         n = 0;
        while (got != 4'hF && n < 400) begin
            @(negedge clk);
            n++;
            ph = (((cyc - 1) % 10) < 5);
            for (int k = 0; k < 4; k++) begin
                pat = 4'b0001 << k;
                if (anodes == ~pat && !got[k] && (want == 2 || ph == (want == 1))) begin
                    rd_segs[k*7 +: 7] = segments;
                    rd_dps[k]         = dp;
                    got[k]            = 1'b1;
                end
            end
        end
        check("scan_timeout", {28'd0, got}, 32'hF);
    endtask

    // d < 0 leaves the rightmost digit unchecked
    task automatic show(input string tag, input int want, input int a, input int b,
                        input int c, input int d);
        logic [27:0] e;
        logic [27:0] g;
        read_disp(want);
        e = {sg(a), sg(b), sg(c), sg(d)};
        g = rd_segs;
        if (d < 0) g[6:0] = 7'h00;
        check(tag, {4'd0, g}, {4'd0, e});
    endtask

    task automatic pulse(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic wait_ticks(input int base, input int n);
        int w = 0;
        while ((ticks - base) < n && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("tick_wait", {31'd0, (ticks - base) >= n}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_seg"},  {25'd0, segments}, 32'h7F);
        check({pfx, "_dp"},   {31'd0, dp},       32'd1);
        check({pfx, "_an"},   {28'd0, anodes},   32'hF);
        check({pfx, "_pm"},   {31'd0, pm},       32'd0);
        check({pfx, "_edit"}, {30'd0, edit},     32'd0);
        check({pfx, "_tick"}, {31'd0, tick_1hz}, 32'd0);
    endtask

    initial begin
        int  tcount;
        int  werr;
        bit  prev;
        int  base;
        int  w;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // 600 one-second ticks from reset
        tcount = 0; werr = 0; prev = 1'b0;
        repeat (6005) begin
            @(negedge clk);
            if (tick_1hz) tcount++;
            if (tick_1hz && prev) werr++;
            prev = tick_1hz;
        end
        check("tick_count", tcount, 600);
        check("tick_width", werr, 0);
        show("run600_hhmm", 2, 0, 0, 1, 0);
        view_sec = 1'b1;
        show("run600_mmss", 2, 1, 0, 0, -1);
        view_sec = 1'b0;
        check("pm_24h_0", {31'd0, pm}, 32'd0);

        // Set hours: entering SET_HR zeroes seconds and freezes time
        repeat (30) @(negedge clk);
        pulse(1, 0);
        check("edit_sethr", {30'd0, edit}, 32'd1);
        view_sec = 1'b1;
        show("sethr_sec0", 2, 1, 0, 0, 0);
        repeat (50) @(negedge clk);
        show("sethr_frozen", 2, 1, 0, 0, 0);
        view_sec = 1'b0;
        repeat (23) pulse(0, 1);
        show("hr23_on", 1, 2, 3, 1, 0);
        check("dp_set_on", {28'd0, rd_dps}, 32'hB);
        show("hr23_blink", 0, B, B, 1, 0);
        check("dp_set_off", {28'd0, rd_dps}, 32'hB);
        mode_12h = 1'b1;
        #1;
        check("pm_hr23", {31'd0, pm}, 32'd1);
        show("hr23_12h", 1, 1, 1, 1, 0);
        mode_12h = 1'b0;

        // Set minutes, including the 59 -> 0 wrap with no hour carry
        pulse(1, 0);
        check("edit_setmin", {30'd0, edit}, 32'd2);
        repeat (49) pulse(0, 1);
        show("min59_on", 1, 2, 3, 5, 9);
        show("min59_blink", 0, 2, 3, B, B);
        view_sec = 1'b1;
        show("min_blink_mmss", 0, B, B, 0, 0);
        view_sec = 1'b0;
        pulse(0, 1);
        show("min_wrap", 1, 2, 3, 0, 0);
        repeat (59) pulse(0, 1);
        pulse(1, 1);
        base = ticks;
        check("edit_run_both", {30'd0, edit}, 32'd0);
        show("both_min_kept", 1, 2, 3, 5, 9);
        check("dp_run_on", {28'd0, rd_dps}, 32'hB);
        show("dp_run_off_rd", 0, 2, 3, 5, 9);
        check("dp_run_off", {28'd0, rd_dps}, 32'hF);

        // Midnight rollover
        wait_ticks(base, 51);
        view_sec = 1'b1;
        show("pre_mid_mmss", 2, 5, 9, 5, -1);
        view_sec = 1'b0;
        show("pre_mid_hhmm", 2, 2, 3, 5, 9);
        wait_ticks(base, 60);
        show("midnight_hhmm", 2, 0, 0, 0, 0);
        view_sec = 1'b1;
        show("midnight_mmss", 2, 0, 0, 0, -1);
        view_sec = 1'b0;

        // 12-hour display
        mode_12h = 1'b1;
        #1;
        check("pm_hr0", {31'd0, pm}, 32'd0);
        show("h0_12h", 2, 1, 2, 0, 0);
        pulse(1, 0);
        repeat (12) pulse(0, 1);
        check("pm_hr12", {31'd0, pm}, 32'd1);
        show("h12_12h", 1, 1, 2, 0, 0);
        pulse(0, 1);
        check("pm_hr13", {31'd0, pm}, 32'd1);
        show("h13_12h", 1, 0, 1, 0, 0);
        mode_12h = 1'b0;
        #1;
        check("pm_hr13_24h", {31'd0, pm}, 32'd0);
        show("h13_24h", 1, 1, 3, 0, 0);

        // Anode scan order, aligned to the start of digit 0
        @(negedge clk);
        prev = 1'b0;
        w = 0;
        while (!(prev && anodes == 4'b1110) && w < 100) begin
            prev = (anodes == 4'b0111);
            @(negedge clk);
            w++;
        end
        check("scan_d0", {28'd0, anodes}, 32'hE);
        repeat (4) @(negedge clk);
        check("scan_d1", {28'd0, anodes}, 32'hD);
        repeat (4) @(negedge clk);
        check("scan_d2", {28'd0, anodes}, 32'hB);
        repeat (4) @(negedge clk);
        check("scan_d3", {28'd0, anodes}, 32'h7);

        // Reset asserted in the middle of SET_MIN
        pulse(1, 0);
        check("edit_setmin2", {30'd0, edit}, 32'd2);
        mode_12h = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        show("after_rst_12h", 2, 1, 2, 0, 0);
        mode_12h = 1'b0;
        show("after_rst_24h", 2, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
